// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - Galois LFSR random number generator with rejection-sampled range limit
// Optional macro LFSR_FREERUN_EN: LFSR also steps while idle, making results timing dependent.
module lfsr_rng #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter int               OUT_W      = 8,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1,
  parameter int               MAX_TRIES  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] q,
  output logic             fallback
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

  typedef enum logic {IDLE, DRAW} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, cnt, stepped, seed_val;
  logic [OUT_W-1:0] lim_r, lim_nxt, lim_m1, mask, cand, q_nxt;
  logic [TRY_W-1:0] tries, tries_nxt, tries_inc;
  logic             valid_nxt, busy_nxt, fb_nxt, accept;

  assign stepped   = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign seed_val  = (cnt == '0) ? RESET_SEED : cnt;
  assign lim_m1    = lim_r - 1'b1;
  assign tries_inc = tries + 1'b1;

  // Smear the top set bit of limit-1 downward: smallest 2^k-1 covering [0, limit).
  always_comb begin
    mask = lim_m1;
    for (int i = 0; i < OUT_W; i++) begin
      mask = mask | (mask >> 1);
    end
  end

  assign cand   = stepped[OUT_W-1:0] & mask;
  assign accept = (lim_r == '0) || (cand < lim_r);

  always_comb begin
    fsm_nxt   = fsm;
    lfsr_nxt  = lfsr;
    lim_nxt   = lim_r;
    tries_nxt = tries;
    q_nxt     = q;
    valid_nxt = 1'b0;
    busy_nxt  = busy;
    fb_nxt    = fallback;
    case (fsm)
      IDLE: begin
`ifdef LFSR_FREERUN_EN
        lfsr_nxt = stepped;
`else
        lfsr_nxt = lfsr;
`endif
        if (req) begin
          lim_nxt   = limit;
          tries_nxt = '0;
          busy_nxt  = 1'b1;
          fsm_nxt   = DRAW;
        end
      end
      DRAW: begin
        lfsr_nxt = stepped;
        if (accept) begin
          q_nxt     = cand;
          valid_nxt = 1'b1;
          fb_nxt    = 1'b0;
          busy_nxt  = 1'b0;
          fsm_nxt   = IDLE;
        end else begin
          tries_nxt = tries_inc;
          // cand < 2*limit here, so the subtraction always lands inside the range
          if (tries_inc == MAX_T) begin
            q_nxt     = cand - lim_r;
            valid_nxt = 1'b1;
            fb_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            fsm_nxt   = IDLE;
          end
        end
      end
      default: fsm_nxt = IDLE;
    endcase
    if (seed_load) begin
      lfsr_nxt = seed_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr     <= RESET_SEED;
      cnt      <= '0;
      fsm      <= IDLE;
      lim_r    <= '0;
      tries    <= '0;
      q        <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      fallback <= 1'b0;
    end else begin
      lfsr     <= lfsr_nxt;
      cnt      <= cnt + 1'b1;
      fsm      <= fsm_nxt;
      lim_r    <= lim_nxt;
      tries    <= tries_nxt;
      q        <= q_nxt;
      valid    <= valid_nxt;
      busy     <= busy_nxt;
      fallback <= fb_nxt;
    end
  end

endmodule
